a2d_conv_sched: RTL and testbench

- Scheduler that sequences the external A2D converter over a shared SPI master.
- Round-robins the battery, current, brake and torque channels, one conversion per sample interval.
- Holds the latest 12-bit result per channel; these feed the sensor-conditioning block (batt, curr, torque) and the brake logic.
- Sole owner of the SPI master's snd/done handshake.

---
 rtl/a2d_pkg.sv | 35 +++
 rtl/a2d_slot_seq.sv | 51 +++++
 rtl/a2d_conv_sched.sv | 144 ++++++++++++++
 tb/tb_a2d_conv_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
// CURR_OVERSAMPLE_EN selects the 6-slot order that converts the current channel every other interval.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT1,
    GAP,
    READ,
    WAIT2
  } state_e;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

`ifdef CURR_OVERSAMPLE_EN
  localparam int NUM_SLOTS = 6;
`else
  localparam int NUM_SLOTS = 4;
`endif

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  localparam int INTV_W_FAST = 8;
  localparam int INTV_W_SLOW = 14;

  // Converter command word: channel select in bits [13:11], all else zero.
  function automatic logic [15:0] conv_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_slot_seq.sv
// Slot pointer and slot-to-channel map for the A2D scheduler.
// CURR_OVERSAMPLE_EN switches between the 4-slot and 6-slot channel orders.
module a2d_slot_seq
  import a2d_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [2:0] chnl
);

  logic [SLOT_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (advance) begin
      slot_d = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  // NOTE: chnl gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    chnl = CH_BATT;
`ifdef CURR_OVERSAMPLE_EN
    case (slot_q)
      3'd0:    chnl = CH_BATT;
      3'd1:    chnl = CH_CURR;
      3'd2:    chnl = CH_BRAKE;
      3'd3:    chnl = CH_CURR;
      3'd4:    chnl = CH_TORQUE;
      3'd5:    chnl = CH_CURR;
      default: chnl = CH_BATT;
    endcase
`else
    case (slot_q)
      2'd0:    chnl = CH_BATT;
      2'd1:    chnl = CH_CURR;
      2'd2:    chnl = CH_BRAKE;
      2'd3:    chnl = CH_TORQUE;
      default: chnl = CH_BATT;
    endcase
`endif
  end

endmodule

// File: rtl/a2d_conv_sched.sv
// Sequences the external A2D over the shared SPI master: one channel per sample interval, round-robin.
// Define CURR_OVERSAMPLE_EN to convert the current channel every other interval.
module a2d_conv_sched
  import a2d_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        smpl_vld,
  output logic [2:0]  smpl_chnl
);

  localparam int INTV_W = FAST_SIM ? INTV_W_FAST : INTV_W_SLOW;

  logic [INTV_W-1:0] intv_q, intv_d;
  logic              trig;

  state_e            state_q, state_d;
  logic              snd_q, snd_d;
  logic [15:0]       cmd_q, cmd_d;
  logic [11:0]       batt_q, batt_d, curr_q, curr_d, brake_q, brake_d, torque_q, torque_d;
  logic              smpl_vld_q, smpl_vld_d;
  logic [2:0]        smpl_chnl_q, smpl_chnl_d;

  logic              advance;
  logic [2:0]        chnl;

  // The converter's status nibble carries nothing the scheduler needs.
  logic unused_resp_hi;
  assign unused_resp_hi = ^resp[15:12];

  a2d_slot_seq u_slot_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .chnl    (chnl)
  );

  always_comb begin
    intv_d = intv_q + INTV_W'(1);
    trig   = &intv_q;
  end

  // Two SPI transactions per conversion: channel select, then a dummy word that clocks the result out.
  always_comb begin
    state_d = state_q;
    snd_d   = 1'b0;
    cmd_d   = cmd_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = CMD;
          snd_d   = 1'b1;
          cmd_d   = conv_cmd(chnl);
        end
      end
      CMD:   state_d = WAIT1;
      WAIT1: begin
        if (done) begin
          state_d = GAP;
          cmd_d   = 16'h0000;
        end
      end
      GAP: begin
        state_d = READ;
        snd_d   = 1'b1;
      end
      READ:  state_d = WAIT2;
      WAIT2: begin
        if (done) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    batt_d      = batt_q;
    curr_d      = curr_q;
    brake_d     = brake_q;
    torque_d    = torque_q;
    smpl_vld_d  = advance;
    smpl_chnl_d = smpl_chnl_q;
    if (advance) begin
      smpl_chnl_d = chnl;
      case (chnl)
        CH_BATT:   batt_d   = resp[11:0];
        CH_CURR:   curr_d   = resp[11:0];
        CH_BRAKE:  brake_d  = resp[11:0];
        CH_TORQUE: torque_d = resp[11:0];
        default:   ;
      endcase
    end
  end

  // NOTE: every flop here is reset; these are a few control and result registers, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intv_q      <= '0;
      state_q     <= IDLE;
      snd_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      batt_q      <= '0;
      curr_q      <= '0;
      brake_q     <= '0;
      torque_q    <= '0;
      smpl_vld_q  <= 1'b0;
      smpl_chnl_q <= '0;
    end else begin
      intv_q      <= intv_d;
      state_q     <= state_d;
      snd_q       <= snd_d;
      cmd_q       <= cmd_d;
      batt_q      <= batt_d;
      curr_q      <= curr_d;
      brake_q     <= brake_d;
      torque_q    <= torque_d;
      smpl_vld_q  <= smpl_vld_d;
      smpl_chnl_q <= smpl_chnl_d;
    end
  end

  assign snd       = snd_q;
  assign cmd       = cmd_q;
  assign batt      = batt_q;
  assign curr      = curr_q;
  assign brake     = brake_q;
  assign torque    = torque_q;
  assign smpl_vld  = smpl_vld_q;
  assign smpl_chnl = smpl_chnl_q;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// Randomized bench for a2d_conv_sched (FAST_SIM=1) with an SPI responder and a cycle-level reference model.
// Build with CURR_OVERSAMPLE_EN defined to check the 6-slot channel order.
module tb_a2d_conv_sched;

  localparam int INTV = 256;
`ifdef CURR_OVERSAMPLE_EN
  localparam int NS = 6;
`else
  localparam int NS = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [15:0] resp;
  logic        snd;
  logic [15:0] cmd;
  logic [11:0] batt, curr, brake, torque;
  logic        smpl_vld;
  logic [2:0]  smpl_chnl;

  int n_cmp = 0;
  int n_err = 0;

  int          spi_delay   = 20;
  bit          inject_done = 1'b0;
  bit          fixed_valid = 1'b0;
  logic [15:0] fixed_resp  = 16'h0000;

  // Reference model state, also read by the stimulus process.
  int          cyc;
  int          upd_cnt = 0;
  bit          busy, first_act, read_pend, read_act;
  int          first_snd_cyc, read_due, read_snd_cyc, slot;
  logic [11:0] exp_res [8];

  a2d_conv_sched #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .resp      (resp),
    .snd       (snd),
    .cmd       (cmd),
    .batt      (batt),
    .curr      (curr),
    .brake     (brake),
    .torque    (torque),
    .smpl_vld  (smpl_vld),
    .smpl_chnl (smpl_chnl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] seq_code(input int s);
    logic [2:0] c;
`ifdef CURR_OVERSAMPLE_EN
    case (s)
      0: c = 3'd0;
      1: c = 3'd1;
      2: c = 3'd3;
      3: c = 3'd1;
      4: c = 3'd4;
      default: c = 3'd1;
    endcase
`else
    case (s)
      0: c = 3'd0;
      1: c = 3'd1;
      2: c = 3'd3;
      default: c = 3'd4;
    endcase
`endif
    return c;
  endfunction

  task automatic model_reset();
    cyc       = 0;
    busy      = 1'b0;
    first_act = 1'b0;
    read_pend = 1'b0;
    read_act  = 1'b0;
    slot      = 0;
    for (int i = 0; i < 8; i++) exp_res[i] = 12'h000;
  endtask

  // SPI responder: done a fixed delay after each snd; resp random unless a fixed read value is armed.
  initial begin : spi_model
    int pending;
    bit rd, pend_rd;
    pending = 0;
    rd      = 1'b0;
    pend_rd = 1'b0;
    done    = 1'b0;
    resp    = 16'h0000;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        pending = 0;
        rd      = 1'b0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            done = 1'b1;
            if (pend_rd && fixed_valid) begin
              resp        = fixed_resp;
              fixed_valid = 1'b0;
            end else begin
              resp = 16'($urandom);
            end
          end
        end else if (inject_done) begin
          done        = 1'b1;
          resp        = 16'($urandom);
          inject_done = 1'b0;
        end
        if (snd) begin
          pending = spi_delay;
          pend_rd = rd;
          rd      = ~rd;
        end
      end
    end
  end

  // Cycle n = posedges since reset release; trig in cycle n-1 when n is a multiple of the interval.
  initial begin : monitor
    bit          exp_snd, exp_vld, just_ended;
    logic [15:0] exp_cmd;
    logic [2:0]  exp_chnl;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        model_reset();
        check("rst_ctl", {snd, smpl_vld, smpl_chnl, cmd}, 64'h0);
        check("rst_res", {batt, curr, brake, torque}, 64'h0);
      end else begin
        cyc++;
        exp_snd    = 1'b0;
        exp_vld    = 1'b0;
        just_ended = 1'b0;
        exp_chnl   = 3'd0;
        // done/resp still hold what the DUT sampled at this edge (driven during cycle cyc-1).
        if (done) begin
          if (first_act && (cyc - 1 > first_snd_cyc)) begin
            first_act = 1'b0;
            read_pend = 1'b1;
            read_due  = cyc + 1;
          end else if (read_act && (cyc - 1 > read_snd_cyc)) begin
            read_act          = 1'b0;
            busy              = 1'b0;
            just_ended        = 1'b1;
            exp_vld           = 1'b1;
            exp_chnl          = seq_code(slot);
            exp_res[exp_chnl] = resp[11:0];
            slot              = (slot + 1) % NS;
            upd_cnt++;
          end
        end
        exp_cmd = first_act ? {2'b00, seq_code(slot), 11'h000} : 16'h0000;
        if (!busy && !just_ended && (cyc % INTV == 0)) begin
          busy          = 1'b1;
          first_act     = 1'b1;
          first_snd_cyc = cyc;
          exp_snd       = 1'b1;
          exp_cmd       = {2'b00, seq_code(slot), 11'h000};
        end
        if (read_pend && cyc == read_due) begin
          read_pend    = 1'b0;
          read_act     = 1'b1;
          read_snd_cyc = cyc;
          exp_snd      = 1'b1;
        end
        check("snd", snd, exp_snd);
        check("cmd", cmd, exp_cmd);
        check("smpl_vld", smpl_vld, exp_vld);
        if (exp_vld) check("smpl_chnl", smpl_chnl, exp_chnl);
        check("results", {batt, curr, brake, torque},
              {exp_res[0], exp_res[1], exp_res[3], exp_res[4]});
      end
    end
  end

  task automatic wait_upd(input int k, input int budget);
    int target;
    target = upd_cnt + k;
    for (int i = 0; i < budget && upd_cnt < target; i++) @(posedge clk);
    check("wait_updates", (upd_cnt >= target), 1);
  endtask

  initial begin : main
    bit got;
    rst_n       = 1'b0;
    fixed_resp  = 16'hFABC;
    fixed_valid = 1'b1;
    spi_delay   = 20;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First conversion: batt, read data FABC.
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (smpl_vld) got = 1'b1;
    end
    check("first_vld_seen", got, 1);
    check("first_batt", batt, 12'hABC);
    check("first_chnl", smpl_chnl, 3'd0);

    // Full rotation plus wrap back to slot 0.
    wait_upd(NS + 1, (NS + 2) * INTV);

    // Slow responder: intervening trigs must be dropped.
    spi_delay = 300;
    wait_upd(3, 4000);
    spi_delay = 20;
    wait_upd(1, 1200);

    // Spurious done while idle.
    @(posedge clk);
    inject_done = 1'b1;
    repeat (10) @(negedge clk);

    // Reset in the middle of the read transaction.
    got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (read_act) got = 1'b1;
    end
    check("read_wait_seen", got, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_upd(2, 1000);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end

endmodule
